tl_ul_arbiter2: RTL

- Two-master TileLink-UL/UH A-channel arbiter with D-channel response router.
- Shares one TileLink slave between two requesters, e.g. instruction and data ports sharing the 32-bit SRAM slave.
- Downstream source is widened by one bit carrying the master index; the D channel is demultiplexed on that bit.
- Multi-beat data-carrying messages keep the grant locked until their final beat.

---
 rtl/tl_pkg.sv | 40 ++++
 rtl/tl_d_router.sv | 68 ++++++
 rtl/tl_ul_arbiter2.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// ==========================================================================
// tl_pkg : TileLink opcodes, arbiter state encoding and beat-count helper.
// Rev 1.0
// ==========================================================================
`default_nettype none

package tl_pkg;

  localparam logic [2:0] TL_PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] TL_ARITHMETIC_DATA  = 3'd2;
  localparam logic [2:0] TL_LOGICAL_DATA     = 3'd3;
  localparam logic [2:0] TL_GET              = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_BURST = 2'd2
  } arb_state_e;

  // Data-carrying messages wider than one 32-bit beat span 2^(size-2) beats;
  // sizes above 12 cannot be represented by the counter and count as one beat.
  function automatic logic [9:0] beats_minus1(input logic [2:0] opcode,
                                              input logic [3:0] size);
    logic [9:0] r;
    logic       has_data;
    r        = '0;
    has_data = (opcode == TL_PUT_FULL_DATA)    ||
               (opcode == TL_PUT_PARTIAL_DATA) ||
               (opcode == TL_ARITHMETIC_DATA)  ||
               (opcode == TL_LOGICAL_DATA);
    if (has_data && (size > 4'd2) && (size <= 4'd12)) begin
      r = 10'((11'd1 << (size - 4'd2)) - 11'd1);
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tl_d_router.sv
// ==========================================================================
// tl_d_router : combinational D-channel demux, selected by the top source bit.
// Rev 1.0
// ==========================================================================
`default_nettype none

module tl_d_router
  import tl_pkg::*;
#(
  parameter int TL_RS = 4
) (
  input  logic             en,
  input  logic [2:0]       s_d_opcode,
  input  logic [1:0]       s_d_param,
  input  logic [3:0]       s_d_size,
  input  logic [TL_RS:0]   s_d_source,
  input  logic             s_d_denied,
  input  logic [31:0]      s_d_data,
  input  logic             s_d_corrupt,
  input  logic             s_d_valid,
  output logic             s_d_ready,
  output logic [2:0]       m0_d_opcode,
  output logic [1:0]       m0_d_param,
  output logic [3:0]       m0_d_size,
  output logic [TL_RS-1:0] m0_d_source,
  output logic             m0_d_denied,
  output logic [31:0]      m0_d_data,
  output logic             m0_d_corrupt,
  output logic             m0_d_valid,
  input  logic             m0_d_ready,
  output logic [2:0]       m1_d_opcode,
  output logic [1:0]       m1_d_param,
  output logic [3:0]       m1_d_size,
  output logic [TL_RS-1:0] m1_d_source,
  output logic             m1_d_denied,
  output logic [31:0]      m1_d_data,
  output logic             m1_d_corrupt,
  output logic             m1_d_valid,
  input  logic             m1_d_ready
);

  logic sel;
  assign sel = s_d_source[TL_RS];

  // Payload is broadcast to both masters; only valid and ready are steered.
  assign m0_d_opcode  = s_d_opcode;
  assign m0_d_param   = s_d_param;
  assign m0_d_size    = s_d_size;
  assign m0_d_source  = s_d_source[TL_RS-1:0];
  assign m0_d_denied  = s_d_denied;
  assign m0_d_data    = s_d_data;
  assign m0_d_corrupt = s_d_corrupt;

  assign m1_d_opcode  = s_d_opcode;
  assign m1_d_param   = s_d_param;
  assign m1_d_size    = s_d_size;
  assign m1_d_source  = s_d_source[TL_RS-1:0];
  assign m1_d_denied  = s_d_denied;
  assign m1_d_data    = s_d_data;
  assign m1_d_corrupt = s_d_corrupt;

  assign m0_d_valid = en && s_d_valid && !sel;
  assign m1_d_valid = en && s_d_valid &&  sel;
  assign s_d_ready  = en && (sel ? m1_d_ready : m0_d_ready);

endmodule

`default_nettype wire

// File: rtl/tl_ul_arbiter2.sv
// ==========================================================================
// tl_ul_arbiter2 : two-master TL-UL arbiter with burst locking and D routing.
// Build option: TL_ARB_FIXED_PRIO_EN (master 0 wins ties, no round-robin).
// Rev 1.0
// ==========================================================================
`default_nettype none

module tl_ul_arbiter2
  import tl_pkg::*;
#(
  parameter int TL_RS = 4,
  parameter int TL_AW = 16
) (
  input  logic             arb_clock_i,
  input  logic             arb_reset_i,

  input  logic [2:0]       m0_a_opcode,
  input  logic [2:0]       m0_a_param,
  input  logic [3:0]       m0_a_size,
  input  logic [TL_RS-1:0] m0_a_source,
  input  logic [TL_AW-1:0] m0_a_address,
  input  logic [3:0]       m0_a_mask,
  input  logic [31:0]      m0_a_data,
  input  logic             m0_a_corrupt,
  input  logic             m0_a_valid,
  output logic             m0_a_ready,
  output logic [2:0]       m0_d_opcode,
  output logic [1:0]       m0_d_param,
  output logic [3:0]       m0_d_size,
  output logic [TL_RS-1:0] m0_d_source,
  output logic             m0_d_denied,
  output logic [31:0]      m0_d_data,
  output logic             m0_d_corrupt,
  output logic             m0_d_valid,
  input  logic             m0_d_ready,

  input  logic [2:0]       m1_a_opcode,
  input  logic [2:0]       m1_a_param,
  input  logic [3:0]       m1_a_size,
  input  logic [TL_RS-1:0] m1_a_source,
  input  logic [TL_AW-1:0] m1_a_address,
  input  logic [3:0]       m1_a_mask,
  input  logic [31:0]      m1_a_data,
  input  logic             m1_a_corrupt,
  input  logic             m1_a_valid,
  output logic             m1_a_ready,
  output logic [2:0]       m1_d_opcode,
  output logic [1:0]       m1_d_param,
  output logic [3:0]       m1_d_size,
  output logic [TL_RS-1:0] m1_d_source,
  output logic             m1_d_denied,
  output logic [31:0]      m1_d_data,
  output logic             m1_d_corrupt,
  output logic             m1_d_valid,
  input  logic             m1_d_ready,

  output logic [2:0]       s_a_opcode,
  output logic [2:0]       s_a_param,
  output logic [3:0]       s_a_size,
  output logic [TL_RS:0]   s_a_source,
  output logic [TL_AW-1:0] s_a_address,
  output logic [3:0]       s_a_mask,
  output logic [31:0]      s_a_data,
  output logic             s_a_corrupt,
  output logic             s_a_valid,
  input  logic             s_a_ready,

  input  logic [2:0]       s_d_opcode,
  input  logic [1:0]       s_d_param,
  input  logic [3:0]       s_d_size,
  input  logic [TL_RS:0]   s_d_source,
  input  logic             s_d_denied,
  input  logic [31:0]      s_d_data,
  input  logic             s_d_corrupt,
  input  logic             s_d_valid,
  output logic             s_d_ready
);

  arb_state_e st;
  logic       grant_q;
  logic [9:0] cnt;
  logic       grant_idle;
  logic       grant;
  logic       accept;
  logic [9:0] beats_m1;

`ifdef TL_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_idle = 1'b0;
    if (m1_a_valid && !m0_a_valid) grant_idle = 1'b1;
  end
`else
  logic rr_q;

  always_comb begin
    grant_idle = rr_q;
    if (m0_a_valid && !m1_a_valid)      grant_idle = 1'b0;
    else if (m1_a_valid && !m0_a_valid) grant_idle = 1'b1;
  end
`endif

  // Once a request is presented it owns the slave until accepted (HOLD) or
  // until its last beat (BURST), keeping the TL valid-stability contract.
  assign grant = (st == ST_IDLE) ? grant_idle : grant_q;

  assign s_a_opcode  = grant ? m1_a_opcode  : m0_a_opcode;
  assign s_a_param   = grant ? m1_a_param   : m0_a_param;
  assign s_a_size    = grant ? m1_a_size    : m0_a_size;
  assign s_a_source  = {grant, (grant ? m1_a_source : m0_a_source)};
  assign s_a_address = grant ? m1_a_address : m0_a_address;
  assign s_a_mask    = grant ? m1_a_mask    : m0_a_mask;
  assign s_a_data    = grant ? m1_a_data    : m0_a_data;
  assign s_a_corrupt = grant ? m1_a_corrupt : m0_a_corrupt;
  assign s_a_valid   = !arb_reset_i && (grant ? m1_a_valid : m0_a_valid);

  assign m0_a_ready  = !arb_reset_i && !grant && s_a_ready;
  assign m1_a_ready  = !arb_reset_i &&  grant && s_a_ready;

  assign accept   = s_a_valid && s_a_ready;
  assign beats_m1 = beats_minus1(s_a_opcode, s_a_size);

  always_ff @(posedge arb_clock_i) begin
    if (arb_reset_i) begin
      st      <= ST_IDLE;
      grant_q <= 1'b0;
      cnt     <= '0;
`ifndef TL_ARB_FIXED_PRIO_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      case (st)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            if (beats_m1 == 10'd0) begin
              st   <= ST_IDLE;
`ifndef TL_ARB_FIXED_PRIO_EN
              rr_q <= ~grant;
`endif
            end else begin
              // The first beat is consumed here, so the counter tracks the
              // beats still to come minus one.
              st      <= ST_BURST;
              cnt     <= beats_m1 - 10'd1;
              grant_q <= grant;
            end
          end else if (s_a_valid) begin
            st      <= ST_HOLD;
            grant_q <= grant;
          end
        end
        ST_BURST: begin
          if (accept) begin
            if (cnt == 10'd0) begin
              st   <= ST_IDLE;
`ifndef TL_ARB_FIXED_PRIO_EN
              rr_q <= ~grant_q;
`endif
            end else begin
              cnt <= cnt - 10'd1;
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  tl_d_router #(
    .TL_RS (TL_RS)
  ) u_d_router (
    .en           (!arb_reset_i),
    .s_d_opcode   (s_d_opcode),
    .s_d_param    (s_d_param),
    .s_d_size     (s_d_size),
    .s_d_source   (s_d_source),
    .s_d_denied   (s_d_denied),
    .s_d_data     (s_d_data),
    .s_d_corrupt  (s_d_corrupt),
    .s_d_valid    (s_d_valid),
    .s_d_ready    (s_d_ready),
    .m0_d_opcode  (m0_d_opcode),
    .m0_d_param   (m0_d_param),
    .m0_d_size    (m0_d_size),
    .m0_d_source  (m0_d_source),
    .m0_d_denied  (m0_d_denied),
    .m0_d_data    (m0_d_data),
    .m0_d_corrupt (m0_d_corrupt),
    .m0_d_valid   (m0_d_valid),
    .m0_d_ready   (m0_d_ready),
    .m1_d_opcode  (m1_d_opcode),
    .m1_d_param   (m1_d_param),
    .m1_d_size    (m1_d_size),
    .m1_d_source  (m1_d_source),
    .m1_d_denied  (m1_d_denied),
    .m1_d_data    (m1_d_data),
    .m1_d_corrupt (m1_d_corrupt),
    .m1_d_valid   (m1_d_valid),
    .m1_d_ready   (m1_d_ready)
  );

endmodule

`default_nettype wire
